// File: rtl/frame_filler.sv
// Frame-fill engine: takes one colour/frame request and writes that colour to every visible
// pixel of the frame buffer as 8-pixel bursts through the DRAM address and write-data FIFOs.
module frame_filler #(
  parameter int unsigned WIDTH  = 800,
  parameter int unsigned HEIGHT = 600
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          FF_valid,
  input  logic [23:0]   FF_color,
  input  logic [31:0]   FF_frame,
  output logic          FF_ready,
  output logic          FF_done,
  input  logic          af_full,
  input  logic          wdf_full,
  output logic          af_wr_en,
  output logic [30:0]   af_addr_din,
  output logic          wdf_wr_en,
  output logic [127:0]  wdf_din,
  output logic [15:0]   wdf_mask_din
);

  localparam int unsigned ColLastI = WIDTH - 8;
  localparam int unsigned RowLastI = HEIGHT - 1;
  localparam logic [9:0]  ColLast  = ColLastI[9:0];
  localparam logic [9:0]  RowLast  = RowLastI[9:0];

  if ((WIDTH % 8) != 0 || WIDTH < 8 || WIDTH > 1024 || HEIGHT < 1 || HEIGHT > 1024)
  begin : gen_bad_params
    $error("frame_filler: WIDTH must be a multiple of 8 in 8..1024, HEIGHT in 1..1024");
  end

  typedef enum logic [1:0] {
    StIdle,
    StBurstA,
    StBurstB
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pixel_q, pixel_d;
  logic [5:0]  frame_q, frame_d;
  logic [9:0]  row_q, row_d;
  logic [9:0]  col_q, col_d;

  // Only bits [27:22] of the frame base are meaningful here.
  logic unused_frame_bits;
  assign unused_frame_bits = ^{FF_frame[31:28], FF_frame[21:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pixel_q <= '0;
      frame_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      pixel_q <= pixel_d;
      frame_q <= frame_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pixel_d   = pixel_q;
    frame_d   = frame_q;
    row_d     = row_q;
    col_d     = col_q;
    FF_ready  = 1'b0;
    FF_done   = 1'b0;
    af_wr_en  = 1'b0;
    wdf_wr_en = 1'b0;

    unique case (state_q)
      StIdle: begin
        FF_ready = 1'b1;
        if (FF_valid) begin
          pixel_d = {8'h00, FF_color};
          frame_d = FF_frame[27:22];
          row_d   = '0;
          col_d   = '0;
          state_d = StBurstA;
        end
      end

      // Command and first data beat go out together so the DRAM side never sees a
      // command without its data having started.
      StBurstA: begin
        if (!af_full && !wdf_full) begin
          af_wr_en  = 1'b1;
          wdf_wr_en = 1'b1;
          state_d   = StBurstB;
        end
      end

      StBurstB: begin
        if (!wdf_full) begin
          wdf_wr_en = 1'b1;
          if (col_q == ColLast) begin
            col_d = '0;
            if (row_q == RowLast) begin
              FF_done = 1'b1;
              state_d = StIdle;
            end else begin
              row_d   = row_q + 10'd1;
              state_d = StBurstA;
            end
          end else begin
            col_d   = col_q + 10'd8;
            state_d = StBurstA;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Row stride is a fixed 1024 pixels, so the address is a plain bit concatenation.
  assign af_addr_din  = {5'b0, frame_q, row_q, col_q[9:3], 3'b000};
  assign wdf_din      = {4{pixel_q}};
  assign wdf_mask_din = 16'h0000;

endmodule

// File: tb/tb_frame_filler.sv
// Randomized self-checking bench for frame_filler: a queue-based model of the expected bursts
// is built per request and every FIFO push is checked against it.
module tb_frame_filler;

  localparam int unsigned W  = 16;
  localparam int unsigned H  = 2;
  localparam int          NB = (W / 8) * H;

  logic         clk = 1'b0;
  logic         rst;
  logic         FF_valid;
  logic [23:0]  FF_color;
  logic [31:0]  FF_frame;
  logic         FF_ready;
  logic         FF_done;
  logic         af_full;
  logic         wdf_full;
  logic         af_wr_en;
  logic [30:0]  af_addr_din;
  logic         wdf_wr_en;
  logic [127:0] wdf_din;
  logic [15:0]  wdf_mask_din;

  always #5 clk = ~clk;

  frame_filler #(
    .WIDTH  (W),
    .HEIGHT (H)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .FF_valid     (FF_valid),
    .FF_color     (FF_color),
    .FF_frame     (FF_frame),
    .FF_ready     (FF_ready),
    .FF_done      (FF_done),
    .af_full      (af_full),
    .wdf_full     (wdf_full),
    .af_wr_en     (af_wr_en),
    .af_addr_din  (af_addr_din),
    .wdf_wr_en    (wdf_wr_en),
    .wdf_din      (wdf_din),
    .wdf_mask_din (wdf_mask_din)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit          busy = 1'b0;
  logic [30:0] exp_af[$];
  logic [31:0] m_pix;
  int          wd_sent;
  int          cyc;
  int          bp_mode = 0;
  int          exp_stall = 0;
  bit          force_full = 1'b0;
  int          done_count = 0;
  int          fills_expected = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_model(input logic [23:0] color, input logic [31:0] frame);
    logic [5:0]  fr;
    logic [30:0] a;
    fr = frame[27:22];
    m_pix = {8'h00, color};
    exp_af.delete();
    for (int r = 0; r < int'(H); r++) begin
      for (int c = 0; c < int'(W); c += 8) begin
        a = (31'(fr) << 20) + 31'(r * 1024 + c);
        exp_af.push_back(a);
      end
    end
    wd_sent = 0;
    cyc = 0;
    busy = 1'b1;
  endtask

  task automatic step();
    bit was_busy;
    af_full  = 1'b0;
    wdf_full = 1'b0;
    case (bp_mode)
      1: af_full  = busy && cyc >= 3 && cyc <= 7;
      2: wdf_full = busy && cyc >= 2 && cyc <= 4;
      3: begin
        af_full  = ($urandom % 4) == 0;
        wdf_full = ($urandom % 4) == 0;
      end
      default: ;
    endcase
    if (force_full) begin
      af_full  = 1'b1;
      wdf_full = 1'b1;
    end
    @(negedge clk);
    was_busy = busy;
    check_eq("ready", FF_ready, !busy);
    if (FF_done) check_eq("done_with_ready", FF_ready, 1'b0);
    if (!busy && (af_wr_en || wdf_wr_en || FF_done))
      check_eq("idle_activity", {af_wr_en, wdf_wr_en, FF_done}, 3'b000);
    if (busy) begin
      if (af_wr_en) begin
        check_eq("af_full_gate", {af_full, wdf_full}, 2'b00);
        check_eq("af_with_wdf", wdf_wr_en, 1'b1);
        check_eq("af_beat_parity", wd_sent % 2, 0);
        check_eq("af_extra", exp_af.size() > 0, 1'b1);
        if (exp_af.size() > 0) check_eq("af_addr", af_addr_din, exp_af.pop_front());
      end
      if (wdf_wr_en) begin
        check_eq("wdf_full_gate", wdf_full, 1'b0);
        check_eq("wdf_data", wdf_din, {4{m_pix}});
        check_eq("wdf_mask", wdf_mask_din, 16'h0000);
        if (wd_sent % 2 == 0) check_eq("first_beat_af", af_wr_en, 1'b1);
        wd_sent++;
        check_eq("done_at_last", FF_done, wd_sent == 2 * NB);
      end else begin
        check_eq("done_no_push", FF_done, 1'b0);
      end
      if (FF_done) begin
        done_count++;
        check_eq("af_left", exp_af.size(), 0);
        if (exp_stall >= 0) check_eq("done_cycle", cyc, 2 * NB + exp_stall);
        busy = 1'b0;
      end
    end
    if (rst) begin
      busy = 1'b0;
      exp_af.delete();
    end else if (!was_busy && FF_valid) begin
      start_model(FF_color, FF_frame);
    end
    if (busy) cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_fill(input logic [23:0] color, input logic [31:0] frame, input int mode,
                          input int stall, input bit noise);
    int n;
    bp_mode   = mode;
    exp_stall = stall;
    FF_valid  = 1'b1;
    FF_color  = color;
    FF_frame  = frame;
    fills_expected++;
    step();
    FF_valid = 1'b0;
    n = 0;
    while (busy && n < 2000) begin
      if (noise) begin
        FF_valid = ($urandom % 3) == 0;
        FF_color = $urandom;
        FF_frame = $urandom;
      end
      step();
      n++;
    end
    FF_valid = 1'b0;
    check_eq("fill_timeout", busy, 1'b0);
    if (busy) begin
      rst = 1'b1;
      step();
      rst = 1'b0;
    end
    bp_mode = 0;
  endtask

  initial begin
    rst      = 1'b1;
    FF_valid = 1'b0;
    FF_color = '0;
    FF_frame = '0;
    af_full  = 1'b0;
    wdf_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", FF_ready, 1'b1);
    check_eq("rst_done", FF_done, 1'b0);
    check_eq("rst_af_en", af_wr_en, 1'b0);
    check_eq("rst_wdf_en", wdf_wr_en, 1'b0);
    @(posedge clk);
    #1;

    // Plain fill, af back-pressure at burst 2, wdf back-pressure in BURST_B, mid-fill noise
    run_fill(24'h123456, 32'd3 << 22, 0, 0, 1'b0);
    step();
    run_fill(24'h123456, 32'd3 << 22, 1, 5, 1'b0);
    run_fill(24'h123456, 32'd3 << 22, 2, 3, 1'b0);
    run_fill(24'hA5C3E1, 32'hF0C0_0000, 0, 0, 1'b1);

    // Reset after three bursts, then a clean fill from the start
    bp_mode  = 0;
    FF_valid = 1'b1;
    FF_color = 24'h0BEEF0;
    FF_frame = 32'd9 << 22;
    step();
    FF_valid = 1'b0;
    repeat (6) step();
    check_eq("pre_rst_pushes", wd_sent, 6);
    rst        = 1'b1;
    force_full = 1'b1;
    step();
    rst        = 1'b0;
    force_full = 1'b0;
    step();
    check_eq("post_rst_ready", FF_ready, 1'b1);
    run_fill(24'h00FF00, 32'd12 << 22, 0, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      run_fill($urandom, $urandom, 3, -1, 1'b1);
      repeat ($urandom_range(0, 3)) step();
    end

    check_eq("done_total", done_count, fills_expected);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
